stopwatch_ctrl: RTL

- Upstream control stage for the 0-99 BCD seconds counter and 7-segment decode path.
- Conditions the raw board inputs: 2-flop synchronisers and debouncers on a start/stop key, a clear switch and a direction switch.
- Runs an IDLE/RUN/PAUSE/DONE state machine.
- Emits a one-cycle `tick` enable at a 1 s rate (at 50 MHz) while running, plus `clr` and `dir` to the counter.

---
 rtl/stopwatch_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Brief    : Input conditioning and IDLE/RUN/PAUSE/DONE control for the
//            0-99 BCD stopwatch counter (tick, clear and direction outputs).
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
   parameter int TICK_DIV   = 50000000,
   parameter int DEB_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_ss_n,
   input  logic       sw_clr,
   input  logic       sw_dir,
   input  logic       at_limit,
   output logic       tick,
   output logic       clr,
   output logic       dir,
   output logic       running,
   output logic [1:0] state
);

   localparam int c_PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int c_DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(TICK_DIV - 1);
   localparam logic [c_DEB_W-1:0] c_DEB_MAX = c_DEB_W'(DEB_CYCLES - 1);
   // Inactive levels of {sw_dir, sw_clr, key_ss_n}
   localparam logic [2:0]         c_DEB_RST = 3'b001;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [c_PRE_W-1:0] r_pre, w_pre_nxt;
   logic               r_tick, w_tick_nxt;
   logic               r_clr, r_dir, r_running;
   logic [2:0]         w_raw, r_deb, w_deb_nxt;
   logic               w_press;

   assign w_raw = {sw_dir, sw_clr, key_ss_n};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_deb
         logic [1:0]         r_sync;
         logic [c_DEB_W-1:0] r_cnt;
         logic               w_hit;

         assign w_hit          = (r_sync[1] != r_deb[gi]) && (r_cnt == c_DEB_MAX);
         assign w_deb_nxt[gi]  = w_hit ? r_sync[1] : r_deb[gi];

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_sync <= {2{c_DEB_RST[gi]}};
               r_cnt  <= '0;
            end else begin
               r_sync <= {r_sync[0], w_raw[gi]};
               if ((r_sync[1] == r_deb[gi]) || w_hit)
                  r_cnt <= '0;
               else
                  r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_deb <= c_DEB_RST;
      else      r_deb <= w_deb_nxt;
   end

   // Press fires in the same cycle the debounced key commits its fall
   assign w_press = r_deb[0] & ~w_deb_nxt[0];

   always_comb begin
      w_state_nxt = r_state;
      w_pre_nxt   = r_pre;
      w_tick_nxt  = 1'b0;
      if (r_clr) begin
         w_state_nxt = S_IDLE;
         w_pre_nxt   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_pre_nxt = '0;
               if (w_press) w_state_nxt = S_RUN;
            end
            S_RUN: begin
               if (at_limit) begin
                  w_state_nxt = S_DONE;
                  w_pre_nxt   = '0;
               end else begin
                  if (r_pre == c_PRE_MAX) begin
                     w_pre_nxt  = '0;
                     w_tick_nxt = 1'b1;
                  end else begin
                     w_pre_nxt = r_pre + 1'b1;
                  end
                  if (w_press) w_state_nxt = S_PAUSE;
               end
            end
            S_PAUSE: begin
               if (w_press) w_state_nxt = S_RUN;
            end
            default: begin
               w_pre_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_pre     <= '0;
         r_tick    <= 1'b0;
         r_clr     <= 1'b0;
         r_dir     <= 1'b0;
         r_running <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pre     <= w_pre_nxt;
         r_tick    <= w_tick_nxt;
         r_clr     <= r_deb[1];
         r_running <= (w_state_nxt == S_RUN);
         // Direction only tracks the switch while idle so a count never reverses mid-run
         if (r_state == S_IDLE)
            r_dir <= w_deb_nxt[2];
      end
   end

   assign tick    = r_tick;
   assign clr     = r_clr;
   assign dir     = r_dir;
   assign running = r_running;
   assign state   = r_state;

endmodule
`default_nettype wire
